// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op and state encodings for the sequential ALU
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } alu_seq_state_e;

endpackage

// File: rtl/alu_slice.sv
// rtl/alu_slice.sv - combinational SLICE-bit ALU step; msb_cin exists only with ALU_SEQ_FLAGS_EN
module alu_slice
  import alu_pkg::*;
#(
  parameter int SLICE = 8
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             cin,
  input  alu_op_e          op,
  output logic [SLICE-1:0] s,
  output logic             cout
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             msb_cin
`endif
);

  logic [SLICE-1:0] b_eff;
  logic [SLICE:0]   sum;
  logic             arith;

  assign arith = (op == ALU_ADD) || (op == ALU_SUB);
  assign b_eff = (op == ALU_SUB) ? ~b : b;
  assign sum   = {1'b0, a} + {1'b0, b_eff} + {{SLICE{1'b0}}, cin};

  always_comb begin
    s    = '0;
    cout = 1'b0;
    case (op)
      ALU_ADD, ALU_SUB: begin
        s    = sum[SLICE-1:0];
        cout = sum[SLICE];
      end
      ALU_AND: s = a & b;
      ALU_OR:  s = a | b;
      default: s = '0;
    endcase
  end

`ifdef ALU_SEQ_FLAGS_EN
  // Carry into the top bit recovered from the sum bit and its two addend bits.
  assign msb_cin = arith & (sum[SLICE-1] ^ a[SLICE-1] ^ b_eff[SLICE-1]);
`endif

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle WIDTH-bit ALU, SLICE bits per clock; zero/ovf flags with ALU_SEQ_FLAGS_EN
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef ALU_SEQ_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NSLICE - 1);

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_slice
      $fatal(1, "alu_seq: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  alu_seq_state_e   state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_q, b_q, s_next;
  alu_op_e          op_q;
  logic             carry_q;
  logic             ready_en;
  logic             accept, last;

  logic [SLICE-1:0] sl_s;
  logic             sl_cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic             sl_msb_cin;
`endif

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a       (a_q[cnt*SLICE +: SLICE]),
    .b       (b_q[cnt*SLICE +: SLICE]),
    .cin     (carry_q),
    .op      (op_q),
    .s       (sl_s),
    .cout    (sl_cout)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .msb_cin (sl_msb_cin)
`endif
  );

  // ready_en keeps in_ready low until the first edge after reset release.
  assign in_ready  = ready_en && (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == LAST_CNT);

  always_comb begin
    s_next = s;
    s_next[cnt*SLICE +: SLICE] = sl_s;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (last) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ready_en <= 1'b0;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= ALU_ADD;
      carry_q  <= 1'b0;
      s        <= '0;
      cout     <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
      zero     <= 1'b0;
      ovf      <= 1'b0;
`endif
    end else begin
      ready_en <= 1'b1;
      state    <= state_next;
      if (state == IDLE && accept) begin
        a_q     <= a;
        b_q     <= b;
        op_q    <= alu_op_e'(op);
        carry_q <= cin;
        cnt     <= '0;
      end
      if (state == BUSY) begin
        s       <= s_next;
        carry_q <= sl_cout;
        cnt     <= cnt + CNT_W'(1);
        if (last) begin
          // The slice already forces cout low for the logic ops.
          cout <= sl_cout;
`ifdef ALU_SEQ_FLAGS_EN
          zero <= (s_next == '0);
          ovf  <= sl_msb_cin ^ sl_cout;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq (WIDTH=64, SLICE=8)
module tb_alu_seq;

  typedef struct {
    logic [63:0] s;
    logic        cout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic [1:0]  op = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] s;
  logic        cout;
`ifdef ALU_SEQ_FLAGS_EN
  logic        zero;
  logic        ovf;
`endif

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  alu_seq #(.WIDTH(64), .SLICE(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef ALU_SEQ_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                                 input logic c);
    exp_t        e;
    logic [64:0] r;
    logic [63:0] yy;
    yy = (o == 2'b01) ? ~y : y;
    case (o)
      2'b00, 2'b01: r = {1'b0, x} + {1'b0, yy} + {64'd0, c};
      2'b10:        r = {1'b0, x & y};
      default:      r = {1'b0, x | y};
    endcase
    e.s    = r[63:0];
    e.cout = r[64];
    e.zero = (r[63:0] == 64'd0);
    e.ovf  = (o[1] == 1'b0) && (x[63] == yy[63]) && (r[63] != x[63]);
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("s", s, e.s);
        check("cout", {63'd0, cout}, {63'd0, e.cout});
`ifdef ALU_SEQ_FLAGS_EN
        check("zero", {63'd0, zero}, {63'd0, e.zero});
        check("ovf", {63'd0, ovf}, {63'd0, e.ovf});
`endif
      end
    end
  end

  task automatic send(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                      input logic c, input exp_t e);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    op = o; a = x; b = y; cin = c;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("accept_timeout", 64'd1, 64'd0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    op = 2'($urandom_range(0, 3));
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int   lat;
    exp_t e;

    repeat (3) @(posedge clk);
    #1;
    check("rst_s", s, 64'd0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", {63'd0, in_ready}, 64'd1);

    send(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
         '{s: 64'd0, cout: 1'b1, zero: 1'b1, ovf: 1'b0});
    wait_out_valid(lat);
    check("add_latency", 64'(lat), 64'd8);
    drain();

    send(2'b01, 64'd5, 64'd7, 1'b1,
         '{s: 64'hFFFF_FFFF_FFFF_FFFE, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    send(2'b00, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
         '{s: 64'h8000_0000_0000_0000, cout: 1'b0, zero: 1'b0, ovf: 1'b1});
    drain();

    // AND held in DONE while a waiting OR request sits on the input.
    out_ready = 1'b0;
    send(2'b10, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 1'b1,
         '{s: 64'hF000_F000_F000_F000, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    wait_out_valid(lat);
    check("and_latency", 64'(lat), 64'd8);
    in_valid = 1'b1;
    op = 2'b11; a = 64'hF0F0_F0F0_F0F0_F0F0; b = 64'hFF00_FF00_FF00_FF00; cin = 1'b0;
    sb.push_back('{s: 64'hFFF0_FFF0_FFF0_FFF0, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_s", s, 64'hF000_F000_F000_F000);
      check("bp_cout", {63'd0, cout}, 64'd0);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_idle_in_ready", {63'd0, in_ready}, 64'd1);
    check("bp_idle_out_valid", {63'd0, out_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("bp_second_accepted", {63'd0, in_ready}, 64'd0);
    in_valid = 1'b0;
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [1:0]  o;
      logic [63:0] x, y;
      logic        c;
      o = 2'($urandom_range(0, 3));
      x = {$urandom, $urandom};
      y = (i == 0) ? x : {$urandom, $urandom};
      c = 1'($urandom_range(0, 1));
      if (i == 0) begin
        o = 2'b01;
        c = 1'b1;
      end
      e = model(o, x, y, c);
      send(o, x, y, c, e);
    end
    drain();

    send(2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
         '{s: 64'd0, cout: 1'b1, zero: 1'b1, ovf: 1'b0});
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    check("midrst_s", s, 64'd0);
    check("midrst_in_ready", {63'd0, in_ready}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_after", {63'd0, in_ready}, 64'd1);
    send(2'b00, 64'd3, 64'd4, 1'b0, '{s: 64'd7, cout: 1'b0, zero: 1'b0, ovf: 1'b0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
